perf_event_collector: RTL and testbench
=======================================

// Module: perf_event_collector
// PURPOSE
//  Upstream feeder of the hardware performance counters. Accepts multi-count event
//  increments per cycle (e.g. 2 loads committed on 2 ports) from pipeline sources.
//  Buffers them in per-event credit accumulators and drains each as at most one
//  single-bit pulse per cycle, so the 1-bit counter event mux loses no events.
//  Sits between commit/cache/MMU/frontend event sources and the perf counter bank.
// PARAMETERS
//  NumEvents  32  event slots; index = 5-bit mhpmevent selector (slot 0 tied inactive)
//  IncrWidth  2   width of per-cycle increment per slot (max 3 per cycle)
//  PendWidth  4   width of per-slot pending accumulator (saturates at 15)
// PORTS
//  clk_i         in   1                      clock
//  rst_ni        in   1                      asynchronous reset, active low
//  debug_mode_i  in   1                      core in debug mode: freeze all slots
//  flush_i       in   1                      clear all pending credit (mhpmevent/counter write)
//  evt_incr_i    in   NumEvents x IncrWidth  per-slot increment this cycle
//  evt_o         out  NumEvents              per-slot 1-bit event pulse to counter bank
//  busy_o        out  1                      OR of all pending_q != 0
//  ovf_o         out  NumEvents              sticky: slot saturated, credit dropped
//  ovf_clr_i     in   1                      clear all ovf_o bits
// BEHAVIOUR
//  - Reset: pending_q = 0 and ovf_q = 0 for all slots; evt_o = 0, busy_o = 0, ovf_o = 0.
//  - Slot 0: evt_incr_i[0] ignored; pending_q[0] and ovf_q[0] stay 0.
//  - Per slot, normal mode (no bypass):
//    - evt_o[e] = (pending_q[e] != 0) & !debug_mode_i & !flush_i.
//    - pending_d = pending_q - evt_o[e] + evt_incr_i[e].
//    - Arithmetic uses PendWidth+1 bits; result > 2^PendWidth-1 clamps to max and sets ovf_q[e].
//    - Latency: increment at cycle N gives the first pulse at N+1. A count k gives k pulses in consecutive cycles unless more arrives.
//  - debug_mode_i=1: no add, no drain; pending_q holds; evt_o = 0.
//  - flush_i=1: pending_d = 0 for all slots; same-cycle increments discarded; evt_o = 0 this cycle. flush_i beats debug_mode_i.
//  - ovf_o = ovf_q. A same-cycle set beats ovf_clr_i. flush_i does not clear ovf_q.
//  - busy_o is combinational from pending_q only; no gating by debug or flush.
//  - Steady state: an increment of 1 per cycle while pending > 0 holds pending constant; no overflow.
//  - Reset mid-drain: all credit lost; no pulses after reset release until a new increment arrives.
//  - No other state; no handshake with the consumer. The counter bank samples evt_o every cycle.
// CONFIGURATION
//  PERF_EVT_BYPASS_EN defined: zero-latency path.
//    - evt_o[e] = (pending_q[e] != 0 | evt_incr_i[e] != 0) & !debug_mode_i & !flush_i.
//    - pending_d = pending_q + evt_incr_i - evt_o; clamp and ovf rules unchanged.
//    - An increment of 1 into an empty slot pulses the same cycle and leaves pending = 0.
//  PERF_EVT_BYPASS_EN undefined: registered path as above (1-cycle latency).
// STRUCTURE
//  - Shared package (ariane_pkg), add:
//    - localparam PERF_EVT_NUM = 32
//    - typedef logic [1:0] perf_evt_incr_t
//    - typedef enum logic [4:0] perf_evt_e: EVT_NONE=0, EVT_L1I_MISS=1, EVT_L1D_MISS=2, ...,
//      EVT_LOAD=5, EVT_STORE=6, ..., EVT_INT_INSTR=20, EVT_FP_INSTR=21, EVT_BUBBLE=22.
//      Encodings match the counter bank's event selector.
//  - Sub-module perf_evt_credit: one slot (accumulator, clamp, ovf flag).
//    - Ports: clk_i, rst_ni, hold_i, clr_i, incr_i, ovf_clr_i, evt_o, pend_nz_o, ovf_o.
//    - Instantiated NumEvents-1 times in a generate loop. Top level holds the gating and the OR for busy_o.
// TESTING
//  1 Reset, then evt_incr_i[5]=2 for 1 cycle -> evt_o[5]=1 at N+1 and N+2, 0 at N+3; busy_o falls at N+3.
//  2 evt_incr_i[6]=3 for 8 cycles -> pending reaches 15 at cycle 8. Next cycle ovf_o[6]=1 and pending clamped at 15. Then 15 consecutive pulses.
//  3 pending[9]=4, debug_mode_i=1 for 5 cycles with incr=1 -> evt_o[9]=0 throughout, pending still 4. Drains 4 pulses after exit.
//  4 pending[2]=3 with flush_i and incr[2]=2 in the same cycle -> evt_o[2]=0 that cycle, pending=0 next, no pulses after.
//  5 Overflow set and ovf_clr_i in the same cycle -> ovf_o stays 1. A later ovf_clr_i alone -> ovf_o=0.
//  6 With PERF_EVT_BYPASS_EN: empty slot, incr=1 -> evt_o=1 same cycle, pending stays 0. Without the macro: pulse one cycle later.
//  7 evt_incr_i[0]=3 -> evt_o[0], ovf_o[0] and busy_o never assert.

Source files
------------

// File: rtl/perf_event_collector_pkg.sv
// Shared definitions for the performance-event collector: slot count, widths, event selector encodings.
// Optional feature macro: PERF_EVT_BYPASS_EN (zero-latency pulse path).
package perf_event_collector_pkg;

    localparam int unsigned PERF_EVT_NUM = 32;
    localparam int unsigned PERF_INCR_W  = 2;
    localparam int unsigned PERF_PEND_W  = 4;

    typedef logic [PERF_INCR_W-1:0] perf_evt_incr_t;

    // Encodings match the counter bank's mhpmevent selector.
    typedef enum logic [4:0] {
        EVT_NONE        = 5'd0,
        EVT_L1I_MISS    = 5'd1,
        EVT_L1D_MISS    = 5'd2,
        EVT_ITLB_MISS   = 5'd3,
        EVT_DTLB_MISS   = 5'd4,
        EVT_LOAD        = 5'd5,
        EVT_STORE       = 5'd6,
        EVT_EXCEPTION   = 5'd7,
        EVT_EXC_RET     = 5'd8,
        EVT_BRANCH      = 5'd9,
        EVT_JUMP        = 5'd10,
        EVT_CALL        = 5'd11,
        EVT_RET         = 5'd12,
        EVT_MIS_PREDICT = 5'd13,
        EVT_SB_FULL     = 5'd14,
        EVT_IF_EMPTY    = 5'd15,
        EVT_L1I_ACCESS  = 5'd16,
        EVT_L1D_ACCESS  = 5'd17,
        EVT_L1D_WB      = 5'd18,
        EVT_L1I_WB      = 5'd19,
        EVT_INT_INSTR   = 5'd20,
        EVT_FP_INSTR    = 5'd21,
        EVT_BUBBLE      = 5'd22
    } perf_evt_e;

endpackage

// File: rtl/perf_event_collector_if.sv
// Event-source / counter-bank bundle for the performance-event collector.
interface perf_event_collector_if;
    import perf_event_collector_pkg::*;

    logic                                        debug_mode;
    logic                                        flush;
    logic                                        ovf_clr;
    logic [PERF_EVT_NUM-1:0][PERF_INCR_W-1:0]    evt_incr;
    logic [PERF_EVT_NUM-1:0]                     evt;
    logic                                        busy;
    logic [PERF_EVT_NUM-1:0]                     ovf;

    modport master (
        output debug_mode, flush, ovf_clr, evt_incr,
        input  evt, busy, ovf
    );

    modport slave (
        input  debug_mode, flush, ovf_clr, evt_incr,
        output evt, busy, ovf
    );

endinterface

// File: rtl/perf_event_collector_credit.sv
// One event slot: saturating credit accumulator drained one pulse per cycle, sticky overflow flag.
// PERF_EVT_BYPASS_EN lets a same-cycle increment pulse immediately.
module perf_evt_credit
    import perf_event_collector_pkg::*;
#(
    parameter int unsigned IncrWidth = PERF_INCR_W,
    parameter int unsigned PendWidth = PERF_PEND_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 hold_i,
    input  logic                 clr_i,
    input  logic [IncrWidth-1:0] incr_i,
    input  logic                 ovf_clr_i,
    output logic                 evt_o,
    output logic                 pend_nz_o,
    output logic                 ovf_o
);

    localparam int unsigned            SumW    = PendWidth + 1;
    localparam logic [PendWidth-1:0]   PendMax = {PendWidth{1'b1}};

    logic [PendWidth-1:0] r_pending;
    logic [PendWidth-1:0] w_pending_d;
    logic                 r_ovf;
    logic                 w_ovf_d;
    logic                 w_evt;
    logic                 w_sat;
    logic [SumW-1:0]      w_sum;

`ifdef PERF_EVT_BYPASS_EN
    assign w_evt = ((r_pending != {PendWidth{1'b0}}) | (incr_i != {IncrWidth{1'b0}})) & ~hold_i & ~clr_i;
`else
    assign w_evt = (r_pending != {PendWidth{1'b0}}) & ~hold_i & ~clr_i;
`endif

    // One extra bit of headroom so the clamp can see a carry past the maximum.
    assign w_sum = {1'b0, r_pending} + SumW'(incr_i) - SumW'(w_evt);

    // Next credit and overflow: flush wins over hold, a fresh saturation wins over clear.
    always_comb begin
        w_sat       = 1'b0;
        w_pending_d = r_pending;
        if (clr_i) begin
            w_pending_d = {PendWidth{1'b0}};
        end else if (hold_i) begin
            w_pending_d = r_pending;
        end else if (w_sum > {1'b0, PendMax}) begin
            w_pending_d = PendMax;
            w_sat       = 1'b1;
        end else begin
            w_pending_d = w_sum[PendWidth-1:0];
        end

        w_ovf_d = r_ovf;
        if (w_sat) begin
            w_ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            w_ovf_d = 1'b0;
        end else begin
            w_ovf_d = r_ovf;
        end
    end

    // Slot state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= {PendWidth{1'b0}};
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_pending_d;
            r_ovf     <= w_ovf_d;
        end
    end

    assign evt_o     = w_evt;
    assign pend_nz_o = (r_pending != {PendWidth{1'b0}});
    assign ovf_o     = r_ovf;

endmodule

// File: rtl/perf_event_collector.sv
// Buffers multi-count per-cycle event increments and drains them as 1-bit pulses to the counter bank.
// Optional feature macro: PERF_EVT_BYPASS_EN (zero-latency pulse path, handled inside each slot).
module perf_event_collector
    import perf_event_collector_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    perf_event_collector_if.slave         bus
);

    logic [PERF_EVT_NUM-1:0] w_evt;
    logic [PERF_EVT_NUM-1:0] w_pend_nz;
    logic [PERF_EVT_NUM-1:0] w_ovf;
    logic                    w_unused_slot0;

    // Slot 0 is the "no event" selector and never accumulates.
    assign w_evt[0]       = 1'b0;
    assign w_pend_nz[0]   = 1'b0;
    assign w_ovf[0]       = 1'b0;
    assign w_unused_slot0 = ^bus.evt_incr[0];

    for (genvar e = 1; e < PERF_EVT_NUM; e++) begin : g_slot
        perf_evt_credit #(
            .IncrWidth (PERF_INCR_W),
            .PendWidth (PERF_PEND_W)
        ) u_credit (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .hold_i    (bus.debug_mode),
            .clr_i     (bus.flush),
            .incr_i    (bus.evt_incr[e]),
            .ovf_clr_i (bus.ovf_clr),
            .evt_o     (w_evt[e]),
            .pend_nz_o (w_pend_nz[e]),
            .ovf_o     (w_ovf[e])
        );
    end

    assign bus.evt  = w_evt;
    assign bus.busy = |w_pend_nz;
    assign bus.ovf  = w_ovf;

endmodule

// File: tb/tb_perf_event_collector.sv
// Scoreboarded bench for perf_event_collector; expectations follow the bypass macro when it is defined.
module tb_perf_event_collector;
    import perf_event_collector_pkg::*;

    localparam int N = PERF_EVT_NUM;
`ifdef PERF_EVT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [N-1:0][PERF_INCR_W-1:0] incr_vec_t;
    typedef struct {
        logic [N-1:0] evt;
        logic         busy;
        logic [N-1:0] ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perf_event_collector_if bus ();

    perf_event_collector u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_pend [N];
    bit   m_ovf  [N];
    exp_t sb_q [$];

    logic [N-1:0] s_evt;
    logic [N-1:0] s_ovf;
    logic         s_busy;

    exp_t mon_x;
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_x = sb_q.pop_front();
            n_checks += 3;
            if (bus.evt !== mon_x.evt) begin
                n_fail++;
                $display("FAIL sb_evt t=%0t got=%h exp=%h", $time, bus.evt, mon_x.evt);
            end
            if (bus.busy !== mon_x.busy) begin
                n_fail++;
                $display("FAIL sb_busy t=%0t got=%b exp=%b", $time, bus.busy, mon_x.busy);
            end
            if (bus.ovf !== mon_x.ovf) begin
                n_fail++;
                $display("FAIL sb_ovf t=%0t got=%h exp=%h", $time, bus.ovf, mon_x.ovf);
            end
        end
    end

    // One clock: drive inputs, predict outputs, sample mid-cycle, advance the reference model.
    task automatic drive(input incr_vec_t incr, input logic dbg, input logic fl, input logic oc);
        exp_t x;
        int   sum;
        bit   nz;
        bit   set;
        bus.evt_incr   = incr;
        bus.debug_mode = dbg;
        bus.flush      = fl;
        bus.ovf_clr    = oc;
        x.evt  = '0;
        x.busy = 1'b0;
        x.ovf  = '0;
        for (int e = 1; e < N; e++) begin
            nz = (m_pend[e] != 0) || (BYP && (int'(incr[e]) != 0));
            x.evt[e] = nz && !dbg && !fl;
            if (m_pend[e] != 0) x.busy = 1'b1;
            x.ovf[e] = m_ovf[e];
        end
        sb_q.push_back(x);
        @(negedge clk);
        s_evt  = bus.evt;
        s_ovf  = bus.ovf;
        s_busy = bus.busy;
        @(posedge clk);
        for (int e = 1; e < N; e++) begin
            set = 1'b0;
            if (fl) begin
                m_pend[e] = 0;
            end else if (!dbg) begin
                sum = m_pend[e] + int'(incr[e]) - int'(x.evt[e]);
                if (sum > 15) begin
                    m_pend[e] = 15;
                    set = 1'b1;
                end else begin
                    m_pend[e] = sum;
                end
            end
            if (set) m_ovf[e] = 1'b1;
            else if (oc) m_ovf[e] = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        drive('0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic incr_vec_t one(input int slot, input int val);
        incr_vec_t v;
        v = '0;
        v[slot] = val[PERF_INCR_W-1:0];
        return v;
    endfunction

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.evt_incr   = '0;
        bus.debug_mode = 1'b0;
        bus.flush      = 1'b0;
        bus.ovf_clr    = 1'b0;
        for (int e = 0; e < N; e++) begin
            m_pend[e] = 0;
            m_ovf[e]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.evt !== '0 || bus.busy !== 1'b0 || bus.ovf !== '0) begin
            n_fail++;
            $display("FAIL reset evt=%h busy=%b ovf=%h exp=0", bus.evt, bus.busy, bus.ovf);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_latency();
        drive(one(5, 2), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (s_evt[5] !== BYP) begin n_fail++; $display("FAIL lat_n0 got=%b exp=%b", s_evt[5], BYP); end
        idle();
        n_checks += 2;
        if (s_evt[5] !== 1'b1) begin n_fail++; $display("FAIL lat_n1 got=%b exp=1", s_evt[5]); end
        if (s_busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy1 got=%b exp=1", s_busy); end
        idle();
        n_checks++;
        if (s_evt[5] !== !BYP) begin n_fail++; $display("FAIL lat_n2 got=%b exp=%b", s_evt[5], !BYP); end
        idle();
        n_checks += 2;
        if (s_evt[5] !== 1'b0) begin n_fail++; $display("FAIL lat_n3 got=%b exp=0", s_evt[5]); end
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy3 got=%b exp=0", s_busy); end
    endtask

    task automatic test_saturate();
        int cnt = 0;
        repeat (8) drive(one(6, 3), 1'b0, 1'b0, 1'b0);
        idle();
        n_checks++;
        if (s_ovf[6] !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got=%b exp=1", s_ovf[6]); end
        if (s_evt[6]) cnt++;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (s_evt[6]) cnt++;
        end
        n_checks++;
        if (cnt != 15) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=15", cnt); end
        drive('0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_debug();
        int cnt = 0;
        drive(one(9, BYP ? 3 : 2), 1'b0, 1'b0, 1'b0);
        drive(one(9, 3), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(one(9, 1), 1'b1, 1'b0, 1'b0);
            n_checks += 2;
            if (s_evt[9] !== 1'b0) begin n_fail++; $display("FAIL dbg_evt cyc=%0d got=%b exp=0", i, s_evt[9]); end
            if (s_busy !== 1'b1) begin n_fail++; $display("FAIL dbg_busy cyc=%0d got=%b exp=1", i, s_busy); end
        end
        for (int i = 0; i < 10; i++) begin
            idle();
            if (s_evt[9]) cnt++;
        end
        n_checks++;
        if (cnt != 4) begin n_fail++; $display("FAIL dbg_pulses got=%0d exp=4", cnt); end
    endtask

    task automatic test_flush();
        drive(one(2, 3), 1'b0, 1'b0, 1'b0);
        drive(one(2, BYP ? 2 : 1), 1'b0, 1'b0, 1'b0);
        drive(one(2, 2), 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (s_evt[2] !== 1'b0) begin n_fail++; $display("FAIL flush_evt got=%b exp=0", s_evt[2]); end
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks += 2;
            if (s_evt[2] !== 1'b0) begin n_fail++; $display("FAIL flush_after cyc=%0d got=%b exp=0", i, s_evt[2]); end
            if (s_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy cyc=%0d got=%b exp=0", i, s_busy); end
        end
    endtask

    task automatic test_ovf_clr();
        repeat (7) drive(one(7, 3), 1'b0, 1'b0, 1'b0);
        drive(one(7, 3), 1'b0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ovf[7] !== 1'b1) begin n_fail++; $display("FAIL ovf_setwins got=%b exp=1", s_ovf[7]); end
        idle();
        n_checks++;
        if (s_ovf[7] !== 1'b1) begin n_fail++; $display("FAIL ovf_flushkeeps got=%b exp=1", s_ovf[7]); end
        drive('0, 1'b0, 1'b0, 1'b1);
        idle();
        n_checks++;
        if (s_ovf[7] !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", s_ovf[7]); end
    endtask

    task automatic test_bypass();
        drive(one(10, 1), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (s_evt[10] !== BYP) begin n_fail++; $display("FAIL byp_n0 got=%b exp=%b", s_evt[10], BYP); end
        idle();
        n_checks += 2;
        if (s_evt[10] !== !BYP) begin n_fail++; $display("FAIL byp_n1 got=%b exp=%b", s_evt[10], !BYP); end
        if (s_busy !== !BYP) begin n_fail++; $display("FAIL byp_busy got=%b exp=%b", s_busy, !BYP); end
        idle();
        n_checks++;
        if (s_evt[10] !== 1'b0) begin n_fail++; $display("FAIL byp_n2 got=%b exp=0", s_evt[10]); end
    endtask

    task automatic test_slot0();
        repeat (8) begin
            drive(one(0, 3), 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (s_evt[0] !== 1'b0 || s_ovf[0] !== 1'b0 || s_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL slot0 evt=%b ovf=%b busy=%b exp=0", s_evt[0], s_ovf[0], s_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        incr_vec_t v;
        for (int c = 0; c < 300; c++) begin
            for (int e = 0; e < N; e++) v[e] = PERF_INCR_W'($urandom_range(0, 3) & $urandom_range(0, 3));
            drive(v, ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 20) == 0));
        end
        repeat (20) idle();
    endtask

    task automatic test_reset_mid();
        drive(one(12, 3), 1'b0, 1'b0, 1'b0);
        drive(one(12, 3), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.evt !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid evt=%h busy=%b exp=0", bus.evt, bus.busy);
        end
        for (int e = 0; e < N; e++) begin
            m_pend[e] = 0;
            m_ovf[e]  = 1'b0;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            n_checks++;
            if (s_evt[12] !== 1'b0) begin n_fail++; $display("FAIL rst_after cyc=%0d got=%b exp=0", i, s_evt[12]); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_saturate();
        test_debug();
        test_flush();
        test_ovf_clr();
        test_bypass();
        test_slot0();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
